// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder is reused over WIDTH cycles, LSB first.
// A carry flip-flop links the bits, and the result is handed off over a valid/ready handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | o_ready=1, waiting for operands
// RUN   | o_busy=1, one result bit per cycle, WIDTH cycles
// DONE  | o_valid=1, result held until downstream takes it
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_carry,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_ff;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_ff),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_sum    <= '0;
      o_carry  <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            a_sr     <= i_operand_a;
            b_sr     <= i_operand_b;
            carry_ff <= i_carry;
            cnt      <= '0;
            state    <= RUN;
            o_ready  <= 1'b0;
            o_busy   <= 1'b1;
          end
        end

        RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= {fa_sum, res_sr[WIDTH-1:1]};
          carry_ff <= fa_cout;
          // The last bit bypasses res_sr so o_sum is complete on the DONE edge.
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            o_sum   <= {fa_sum, res_sr[WIDTH-1:1]};
            o_carry <= fa_cout;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13.
// Expected sums are queued at issue time; monitors pop them when a result is handed off.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst8, valid8, ready8, cin8;
  logic [7:0]  a8, b8;
  logic        rdy8, busy8, ov8, co8;
  logic [7:0]  sum8;

  logic        rst13, valid13, ready13, cin13;
  logic [12:0] a13, b13;
  logic        rdy13, busy13, ov13, co13;
  logic [12:0] sum13;

  logic [8:0]  exp8[$];
  logic [13:0] exp13[$];
  logic [8:0]  e8;
  logic [13:0] e13;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst8), .i_valid(valid8), .o_ready(rdy8),
    .i_operand_a(a8), .i_operand_b(b8), .i_carry(cin8),
    .o_busy(busy8), .o_valid(ov8), .i_ready(ready8),
    .o_sum(sum8), .o_carry(co8)
  );

  serial_adder_ctrl #(.WIDTH(13)) dut13 (
    .i_clk(clk), .i_rst_n(rst13), .i_valid(valid13), .o_ready(rdy13),
    .i_operand_a(a13), .i_operand_b(b13), .i_carry(cin13),
    .o_busy(busy13), .o_valid(ov13), .i_ready(ready13),
    .o_sum(sum13), .o_carry(co13)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (rst8 && ov8 && ready8) begin
      if (exp8.size() == 0) timeout("sb8_unexpected_result");
      else begin
        e8 = exp8.pop_front();
        check("sb8_result", 64'({co8, sum8}), 64'(e8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst13 && ov13 && ready13) begin
      if (exp13.size() == 0) timeout("sb13_unexpected_result");
      else begin
        e13 = exp13.pop_front();
        check("sb13_result", 64'({co13, sum13}), 64'(e13));
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy8 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout("issue8_ready");
    a8 = a; b8 = b; cin8 = c; valid8 = 1'b1;
    exp8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(posedge clk); #1;
    valid8 = 1'b0;
  endtask

  task automatic wait_valid8(input string nm);
    int t;
    t = 0;
    while (!ov8 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!ov8) timeout(nm);
  endtask

  task automatic b2b8(input int n);
    int t, last;
    logic [7:0] a, b;
    logic c;
    last = -1;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!rdy8 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) timeout("b2b8_ready");
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      a8 = a; b8 = b; cin8 = c; valid8 = 1'b1;
      exp8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
      if (last >= 0) check("b2b8_interval", 64'(cyc - last), 64'd10);
      last = cyc;
    end
    @(posedge clk); #1;
    valid8 = 1'b0;
  endtask

  task automatic b2b13(input int n);
    int t, last;
    logic [12:0] a, b;
    logic c;
    last = -1;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!rdy13 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) timeout("b2b13_ready");
      a = 13'($urandom); b = 13'($urandom); c = 1'($urandom);
      a13 = a; b13 = b; cin13 = c; valid13 = 1'b1;
      exp13.push_back({1'b0, a} + {1'b0, b} + 14'(c));
      if (last >= 0) check("b2b13_interval", 64'(cyc - last), 64'd15);
      last = cyc;
    end
    @(posedge clk); #1;
    valid13 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst8 = 1'b0; valid8 = 1'b0; ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst13 = 1'b0; valid13 = 1'b0; ready13 = 1'b1; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst8_ready", rdy8, 1);
    check("rst8_busy", busy8, 0);
    check("rst8_valid", ov8, 0);
    check("rst8_sum", sum8, 0);
    check("rst8_carry", co8, 0);
    check("rst13_ready", rdy13, 1);
    check("rst13_valid", ov13, 0);
    check("rst13_sum", sum13, 0);
    rst8 = 1'b1; rst13 = 1'b1;

    // Timing of one operation: busy for 8 edges, valid after the 8th RUN edge.
    issue8(8'h3C, 8'h05, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check("t1_busy", busy8, 1);
      check("t1_no_valid", ov8, 0);
      check("t1_no_ready", rdy8, 0);
      @(posedge clk); #1;
    end
    check("t1_valid", ov8, 1);
    check("t1_busy_off", busy8, 0);
    check("t1_sum", sum8, 8'h41);
    check("t1_carry", co8, 0);

    issue8(8'hFF, 8'h01, 1'b0);
    wait_valid8("t2_valid");
    check("t2_sum", sum8, 8'h00);
    check("t2_carry", co8, 1);

    // Back-pressure: result must stay put while i_ready is low.
    issue8(8'hFF, 8'hFF, 1'b1);
    ready8 = 1'b0;
    wait_valid8("t3_valid");
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", ov8, 1);
      check("t3_hold_sum", sum8, 8'hFF);
      check("t3_hold_carry", co8, 1);
      check("t3_hold_ready", rdy8, 0);
      @(posedge clk); #1;
    end
    ready8 = 1'b1;
    @(posedge clk); #1;
    check("t3_idle_ready", rdy8, 1);
    check("t3_idle_valid", ov8, 0);
    check("t3_idle_sum_held", sum8, 8'hFF);

    // i_valid during RUN must not disturb the operation in flight.
    issue8(8'h22, 8'h33, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h11; cin8 = 1'b1; valid8 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    wait_valid8("t4_valid");
    check("t4_sum", sum8, 8'h55);
    check("t4_carry", co8, 0);

    // Reset in the middle of RUN discards the operation.
    issue8(8'hAA, 8'h55, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;
    check("t5_rst_ready", rdy8, 1);
    check("t5_rst_valid", ov8, 0);
    check("t5_rst_busy", busy8, 0);
    check("t5_rst_sum", sum8, 0);
    check("t5_rst_carry", co8, 0);
    exp8.delete();
    rst8 = 1'b1;
    issue8(8'h01, 8'h01, 1'b0);
    wait_valid8("t5_valid");
    check("t5_sum", sum8, 8'h02);
    check("t5_carry", co8, 0);

    // Streaming with i_valid and i_ready held high.
    fork
      b2b8(100);
      b2b13(100);
    join

    t = 0;
    while ((exp8.size() != 0 || exp13.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain8_left", exp8.size(), 0);
    check("drain13_left", exp13.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
